// File: rtl/misere_board_engine.sv
`default_nettype none
// ============================================================================
// misere_board_engine : N x N board, K-in-a-row move engine with misere rule
// Rev 1.0
// ============================================================================
module misere_board_engine #(
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int MISERE = 1,
  parameter int PW     = 7
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          new_game,
  input  logic          move_valid,
  input  logic [PW-1:0] move_pos,
  input  logic [1:0]    move_sym,
  output logic          move_ready,
  output logic          illegal,
  output logic [1:0]    turn,
  output logic          game_over,
  output logic [1:0]    result,
  input  logic [PW-1:0] rd_pos,
  output logic [1:0]    rd_sym
);

  localparam int                c_CELLS = N * N;
  localparam logic signed [4:0] c_NS    = 5'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SCAN   = 2'd2,
    DECIDE = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_board [c_CELLS];
  logic [PW-1:0] r_pos;
  logic [1:0]  r_sym, r_turn, r_result, r_mover, r_dir;
  logic        r_game_over, r_illegal, r_back, r_found;
  logic [2:0]  r_org_row, r_org_col, r_cur_row, r_cur_col;
  logic [3:0]  r_count;

  logic [1:0]        w_tgt, w_rd, w_ncell;
  logic [2:0]        w_pos_row, w_pos_col;
  logic signed [4:0] w_dr, w_dc, w_nr, w_nc;
  logic              w_inb, w_match, w_full, w_bad;

  always_comb begin
    w_tgt     = 2'b00;
    w_rd      = 2'b00;
    w_pos_row = 3'd0;
    w_pos_col = 3'd0;
    w_full    = 1'b1;
    for (int i = 0; i < c_CELLS; i++) begin
      if (move_pos == PW'(i)) w_tgt = r_board[i];
      if (rd_pos == PW'(i))   w_rd  = r_board[i];
      if (r_pos == PW'(i)) begin
        w_pos_row = 3'(i / N);
        w_pos_col = 3'(i % N);
      end
      if (r_board[i] == 2'b00) w_full = 1'b0;
    end
  end

  // Neighbour of the scan cursor along the current direction and leg
  always_comb begin
    w_dr = 5'sd0;
    w_dc = 5'sd1;
    case (r_dir)
      2'd1:    begin w_dr = 5'sd1; w_dc = 5'sd0;  end
      2'd2:    begin w_dr = 5'sd1; w_dc = 5'sd1;  end
      2'd3:    begin w_dr = 5'sd1; w_dc = -5'sd1; end
      default: ;
    endcase
    if (r_back) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_nr  = $signed({2'b00, r_cur_row}) + w_dr;
    w_nc  = $signed({2'b00, r_cur_col}) + w_dc;
    w_inb = (w_nr >= 5'sd0) && (w_nr < c_NS) && (w_nc >= 5'sd0) && (w_nc < c_NS);
    w_ncell = 2'b00;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (w_nr == 5'(r) && w_nc == 5'(c)) w_ncell = r_board[r*N + c];
      end
    end
    w_match = w_inb && (w_ncell == r_sym);
  end

  assign w_bad = (move_pos >= PW'(c_CELLS)) || (w_tgt != 2'b00) ||
                 (move_sym == 2'b00) || (move_sym == 2'b11) || r_game_over;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      for (int i = 0; i < c_CELLS; i++) r_board[i] <= 2'b00;
      r_turn      <= 2'b01;
      r_result    <= 2'b00;
      r_game_over <= 1'b0;
      r_illegal   <= 1'b0;
      r_pos       <= '0;
      r_sym       <= 2'b00;
      r_mover     <= 2'b00;
      r_dir       <= 2'd0;
      r_back      <= 1'b0;
      r_found     <= 1'b0;
      r_org_row   <= 3'd0;
      r_org_col   <= 3'd0;
      r_cur_row   <= 3'd0;
      r_cur_col   <= 3'd0;
      r_count     <= 4'd0;
    end else if (new_game) begin
      // Any in-flight move or simultaneous request is simply dropped
      r_state     <= IDLE;
      for (int i = 0; i < c_CELLS; i++) r_board[i] <= 2'b00;
      r_turn      <= 2'b01;
      r_result    <= 2'b00;
      r_game_over <= 1'b0;
      r_illegal   <= 1'b0;
      r_found     <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (move_valid) begin
            if (w_bad) begin
              r_illegal <= 1'b1;
            end else begin
              r_pos   <= move_pos;
              r_sym   <= move_sym;
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          for (int i = 0; i < c_CELLS; i++) begin
            if (r_pos == PW'(i)) r_board[i] <= r_sym;
          end
          r_mover   <= r_turn;
          r_org_row <= w_pos_row;
          r_org_col <= w_pos_col;
          r_cur_row <= w_pos_row;
          r_cur_col <= w_pos_col;
          r_dir     <= 2'd0;
          r_back    <= 1'b0;
          r_count   <= 4'd1;
          r_found   <= 1'b0;
          r_state   <= SCAN;
        end
        SCAN: begin
          // A leg can never exceed K-1 steps: the run count hits K first
          if (w_match) begin
            r_cur_row <= w_nr[2:0];
            r_cur_col <= w_nc[2:0];
            r_count   <= r_count + 4'd1;
            if (r_count + 4'd1 == 4'(K)) begin
              r_found <= 1'b1;
              r_state <= DECIDE;
            end
          end else begin
            r_cur_row <= r_org_row;
            r_cur_col <= r_org_col;
            if (!r_back) begin
              r_back <= 1'b1;
            end else begin
              r_back  <= 1'b0;
              r_count <= 4'd1;
              if (r_dir == 2'd3) r_state <= DECIDE;
              else               r_dir   <= r_dir + 2'd1;
            end
          end
        end
        DECIDE: begin
          if (r_found) begin
            r_game_over <= 1'b1;
            r_result    <= (MISERE != 0) ? ~r_mover : r_mover;
          end else if (w_full) begin
            r_game_over <= 1'b1;
            r_result    <= 2'b11;
          end else begin
            r_turn <= ~r_turn;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign move_ready = (r_state == IDLE);
  assign illegal    = r_illegal;
  assign turn       = r_turn;
  assign game_over  = r_game_over;
  assign result     = r_result;
  assign rd_sym     = w_rd;

endmodule
`default_nettype wire

// File: tb/tb_misere_board_engine.sv
`default_nettype none
// ============================================================================
// tb_misere_board_engine : table, hand-written and random checks of three
// engine configurations against a line-counting board model
// Rev 1.0
// ============================================================================
module tb_misere_board_engine;

  logic       clock = 1'b0;
  logic       resetn, new_game, move_valid;
  logic [6:0] move_pos, rd_pos;
  logic [1:0] move_sym;

  logic       rdy [3];
  logic       ill [3];
  logic       go  [3];
  logic [1:0] trn [3];
  logic [1:0] res [3];
  logic [1:0] rds [3];

  always #5 clock = ~clock;

  misere_board_engine #(.N(3), .K(3), .MISERE(1), .PW(7)) u_dut_a (
    .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_sym(move_sym), .move_ready(rdy[0]), .illegal(ill[0]),
    .turn(trn[0]), .game_over(go[0]), .result(res[0]), .rd_pos(rd_pos), .rd_sym(rds[0]));

  misere_board_engine #(.N(3), .K(3), .MISERE(0), .PW(7)) u_dut_b (
    .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_sym(move_sym), .move_ready(rdy[1]), .illegal(ill[1]),
    .turn(trn[1]), .game_over(go[1]), .result(res[1]), .rd_pos(rd_pos), .rd_sym(rds[1]));

  misere_board_engine #(.N(5), .K(4), .MISERE(1), .PW(7)) u_dut_c (
    .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_sym(move_sym), .move_ready(rdy[2]), .illegal(ill[2]),
    .turn(trn[2]), .game_over(go[2]), .result(res[2]), .rd_pos(rd_pos), .rd_sym(rds[2]));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: board, player to move (1/2), game over, result
  int mn   [3] = '{3, 3, 5};
  int mk   [3] = '{3, 3, 4};
  int mmis [3] = '{1, 0, 1};
  int DR   [4] = '{0, 1, 1, 1};
  int DC   [4] = '{1, 0, 1, -1};
  int mb   [3][64];
  int mturn[3];
  int mgo  [3];
  int mres [3];
  bit obs_ill[3];

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 64; i++) mb[d][i] = 0;
      mturn[d] = 1; mgo[d] = 0; mres[d] = 0;
    end
  endfunction

  function automatic int exp_rd(input int d, input int p);
    return (p < mn[d] * mn[d]) ? mb[d][p] : 0;
  endfunction

  // Plays a move on the model; elat is the cycle count from acceptance to ready
  function automatic void model_move(input int d, input int pos, input int sym,
                                     output bit eill, output int elat);
    int n, r, c, rr, cc, cnt;
    bit found, full;
    n = mn[d]; eill = 0; elat = 0;
    if (pos >= n * n || sym == 0 || sym == 3 || mgo[d] != 0) eill = 1;
    else if (mb[d][pos] != 0) eill = 1;
    if (eill) return;
    mb[d][pos] = sym;
    r = pos / n; c = pos % n; found = 0; elat = 2;
    for (int dir = 0; dir < 4 && !found; dir++) begin
      cnt = 1;
      for (int s = 1; s >= -1 && !found; s -= 2) begin
        rr = r; cc = c;
        while (1) begin
          rr += s * DR[dir]; cc += s * DC[dir]; elat++;
          if (rr < 0 || rr >= n || cc < 0 || cc >= n) break;
          if (mb[d][rr * n + cc] != sym) break;
          cnt++;
          if (cnt >= mk[d]) begin found = 1; break; end
        end
      end
    end
    full = 1;
    for (int i = 0; i < n * n; i++) if (mb[d][i] == 0) full = 0;
    if (found) begin
      mgo[d] = 1; mres[d] = (mmis[d] != 0) ? 3 - mturn[d] : mturn[d];
    end else if (full) begin
      mgo[d] = 1; mres[d] = 3;
    end else begin
      mturn[d] = 3 - mturn[d];
    end
  endfunction

  task automatic check_status(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s turn[%0d]", tag, d), int'(trn[d]), mturn[d]);
      chk($sformatf("%s game_over[%0d]", tag, d), int'(go[d]), mgo[d]);
      chk($sformatf("%s result[%0d]", tag, d), int'(res[d]), mres[d]);
    end
  endtask

  task automatic do_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      obs_ill[d] = ill[d];
      chk($sformatf("newgame ready[%0d]", d), int'(rdy[d]), 1);
      chk($sformatf("newgame illegal[%0d]", d), int'(ill[d]), 0);
    end
    check_status("newgame");
  endtask

  task automatic do_move(input int pos, input int sym);
    bit eill[3];
    int elat[3];
    int lat[3];
    int cyc, rp;
    bit all;
    for (int d = 0; d < 3; d++) model_move(d, pos, sym, eill[d], elat[d]);
    @(negedge clock);
    move_valid = 1'b1; move_pos = 7'(pos); move_sym = 2'(sym);
    @(posedge clock); #1;
    move_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      obs_ill[d] = ill[d];
      chk($sformatf("illegal[%0d] pos=%0d", d, pos), int'(ill[d]), int'(eill[d]));
      lat[d] = rdy[d] ? 0 : -1;
    end
    cyc = 0; all = 0;
    while (cyc < 1 || (!all && cyc < 200)) begin
      @(posedge clock); #1;
      cyc++;
      all = 1;
      for (int d = 0; d < 3; d++) begin
        if (cyc == 1) chk($sformatf("illegal pulse end[%0d]", d), int'(ill[d]), 0);
        if (lat[d] < 0 && rdy[d]) lat[d] = cyc;
        if (lat[d] < 0) all = 0;
      end
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("latency[%0d] pos=%0d", d, pos), lat[d], elat[d]);
    check_status("move");
    rd_pos = 7'(pos); #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rd_sym[%0d] at %0d", d, pos), int'(rds[d]), exp_rd(d, pos));
    rp = int'($urandom_range(0, 27));
    rd_pos = 7'(rp); #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rd_sym[%0d] at %0d", d, rp), int'(rds[d]), exp_rd(d, rp));
  endtask

  typedef struct {
    bit ng;
    int pos;
    int sym;
    int ill;
    int turn;
    int over;
    int res;
    int res_b;
    int rdv;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int sym;
    resetn = 1'b0; new_game = 1'b0; move_valid = 1'b0;
    move_pos = '0; move_sym = '0; rd_pos = '0;
    model_clear();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ready[%0d]", d), int'(rdy[d]), 1);
      chk($sformatf("reset illegal[%0d]", d), int'(ill[d]), 0);
      chk($sformatf("reset rd_sym[%0d]", d), int'(rds[d]), 0);
    end
    check_status("reset");
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    for (int d = 0; d < 3; d++) chk($sformatf("post-reset ready[%0d]", d), int'(rdy[d]), 1);

    // ng, pos, sym, ill, turn, over, res (MISERE=1), res (MISERE=0), rd_sym at pos
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 4, 2, 0, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 1, 1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 8, 2, 0, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 2, 1, 0, 1, 1, 2, 1, 1});
    tbl.push_back('{0, 5, 2, 1, 1, 1, 2, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 4, 1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 4, 2, 1, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 3, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 9, 1, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 2, 2, 0, 2, 0, 0, 0, 2});
    tbl.push_back('{0, 3, 2, 0, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 4, 2, 0, 2, 0, 0, 0, 2});
    tbl.push_back('{0, 5, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 6, 1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{0, 7, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 8, 2, 0, 1, 1, 3, 3, 2});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ng) do_new_game();
      else           do_move(tbl[i].pos, tbl[i].sym);
      chk($sformatf("tbl%0d illegal", i), int'(obs_ill[0]), tbl[i].ill);
      chk($sformatf("tbl%0d turn", i), int'(trn[0]), tbl[i].turn);
      chk($sformatf("tbl%0d game_over", i), int'(go[0]), tbl[i].over);
      chk($sformatf("tbl%0d result", i), int'(res[0]), tbl[i].res);
      chk($sformatf("tbl%0d result misere0", i), int'(res[1]), tbl[i].res_b);
      rd_pos = 7'(tbl[i].pos); #1;
      chk($sformatf("tbl%0d rd_sym", i), int'(rds[0]), tbl[i].rdv);
    end

    // 5x5, run of 4 on the diagonal completed by player 1
    do_new_game();
    do_move(0, 2); do_move(6, 2); do_move(12, 2); do_move(3, 1);
    do_move(25, 1);
    chk("n5 oor illegal", int'(obs_ill[2]), 1);
    chk("n5 oor turn", int'(trn[2]), 1);
    do_move(18, 2);
    chk("n5 run game_over", int'(go[2]), 1);
    chk("n5 run result", int'(res[2]), 2);
    do_move(25, 1);
    chk("n5 oor after end illegal", int'(obs_ill[2]), 1);

    // new_game and move_valid in the same cycle: move dropped silently
    @(negedge clock);
    new_game = 1'b1; move_valid = 1'b1; move_pos = 7'd4; move_sym = 2'b01;
    @(posedge clock); #1;
    new_game = 1'b0; move_valid = 1'b0;
    model_clear();
    rd_pos = 7'd4;
    @(posedge clock); #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("ng+move illegal[%0d]", d), int'(ill[d]), 0);
      chk($sformatf("ng+move ready[%0d]", d), int'(rdy[d]), 1);
      chk($sformatf("ng+move rd_sym[%0d]", d), int'(rds[d]), 0);
    end
    check_status("ng+move");

    // Reset asserted while the engines are scanning
    do_move(0, 1);
    @(negedge clock);
    move_valid = 1'b1; move_pos = 7'd4; move_sym = 2'b10;
    @(posedge clock); #1;
    move_valid = 1'b0;
    @(posedge clock); @(posedge clock); #2;
    for (int d = 0; d < 3; d++) chk($sformatf("pre-reset busy[%0d]", d), int'(rdy[d]), 0);
    resetn = 1'b0; rd_pos = 7'd0; #1;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async reset ready[%0d]", d), int'(rdy[d]), 1);
      chk($sformatf("async reset illegal[%0d]", d), int'(ill[d]), 0);
      chk($sformatf("async reset rd_sym[%0d]", d), int'(rds[d]), 0);
    end
    check_status("async reset");
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    for (int d = 0; d < 3; d++) chk($sformatf("after reset ready[%0d]", d), int'(rdy[d]), 1);

    // Random play across all three configurations
    for (int i = 0; i < 160; i++) begin
      if ((mgo[0] != 0 && mgo[1] != 0 && mgo[2] != 0) || $urandom_range(0, 39) == 0)
        do_new_game();
      if ($urandom_range(0, 9) == 0) sym = ($urandom_range(0, 1) == 1) ? 3 : 0;
      else                           sym = int'($urandom_range(1, 2));
      do_move(int'($urandom_range(0, 27)), sym);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
